sync_nff_filter: RTL

Parametrised multi-bit synchronizer for asynchronous level signals entering the `clk_i` domain. Each of `WIDTH` independent channels passes through a `STAGES`-deep flip-flop chain, then through a per-channel persistence filter. The filter suppresses pulses shorter than `FILTER_CYCLES` destination cycles and emits registered rise/fall pulses. It sits at the boundary of every clock domain that receives slow control or status levels, such as straps, interrupts or enables. It replaces the fixed single-bit two-stage synchronizer used for those signals.

---
 rtl/sync_pkg.sv | 17 +
 rtl/metastability_injector.sv | 46 ++++
 rtl/sync_nff_filter_chain.sv | 48 ++++
 rtl/sync_nff_filter.sv | 94 +++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared sizing helper and metastability-model types for the sync_nff_filter slice.
package sync_pkg;

  typedef enum logic [1:0] {
    MS_NORMAL = 2'd0,
    MS_DELAY  = 2'd1,
    MS_BYPASS = 2'd2
  } ms_mode_e;

  localparam int LFSR_W = 8;

  // Width of a counter that must reach FILTER_CYCLES-1 without wrapping.
  function automatic int filter_cnt_w(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/metastability_injector.sv
// Behavioural model of stages 0/1 of one synchronizer channel: on an input transition a
// free-running LFSR picks a normal, one-cycle-late or one-cycle-early capture.
module metastability_injector
  import sync_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'h5A
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  input  logic s0_i,
  output logic s0_d_o,
  output logic s1_d_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              held_q, held_d;
  ms_mode_e          mode;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    mode   = MS_NORMAL;
    // A late capture is never repeated back to back, bounding the added latency to one cycle.
    if ((d_i != s0_i) && !held_q) begin
      unique case (lfsr_q[1:0])
        2'b00:   mode = MS_DELAY;
        2'b01:   mode = MS_BYPASS;
        default: mode = MS_NORMAL;
      endcase
    end
    held_d = (mode == MS_DELAY);
    s0_d_o = (mode == MS_DELAY)  ? s0_i : d_i;
    s1_d_o = (mode == MS_BYPASS) ? d_i  : s0_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lfsr_q <= SEED | LFSR_W'(1);
      held_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      held_q <= held_d;
    end
  end

endmodule

// File: rtl/sync_nff_filter_chain.sv
// One synchronizer channel: a STAGES-deep flop chain whose first two stages can be
// routed through the metastability model.
module sync_chain
  import sync_pkg::*;
#(
  parameter int                SYNTHESIS   = 0,
  parameter int                STAGES      = 2,
  parameter logic              RESET_VALUE = 1'b0,
  parameter logic [LFSR_W-1:0] SEED        = 8'h5A
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o
);

  logic [STAGES-1:0] s_q;
  logic              s0_d, s1_d;

  if (SYNTHESIS != 0) begin : g_plain
    assign s0_d = d_i;
    assign s1_d = s_q[0];
  end else begin : g_model
    metastability_injector #(
      .SEED (SEED)
    ) u_inj (
      .clk_i  (clk_i),
      .rstn_i (~rst_i),
      .d_i    (d_i),
      .s0_i   (s_q[0]),
      .s0_d_o (s0_d),
      .s1_d_o (s1_d)
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_q <= {STAGES{RESET_VALUE}};
    end else begin
      s_q[0] <= s0_d;
      s_q[1] <= s1_d;
      for (int k = 2; k < STAGES; k++) s_q[k] <= s_q[k-1];
    end
  end

  assign sync_o = s_q[STAGES-1];

endmodule

// File: rtl/sync_nff_filter.sv
// Multi-bit level synchronizer with per-channel persistence filter, edge pulses and
// a saturating count of aborted changes.
module sync_nff_filter
  import sync_pkg::*;
#(
  parameter int               SYNTHESIS     = 0,
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int               GCNT_W        = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic              clr_i,
  output logic [WIDTH-1:0]  q_o,
  output logic [WIDTH-1:0]  rise_o,
  output logic [WIDTH-1:0]  fall_o,
  output logic [GCNT_W-1:0] glitch_cnt_o
);

  localparam int CNT_W = filter_cnt_w(FILTER_CYCLES);
  typedef logic [CNT_W-1:0] sync_cnt_t;
  localparam sync_cnt_t CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0]  sync_w;
  logic [WIDTH-1:0]  q_q, q_d, rise_q, rise_d, fall_q, fall_d;
  sync_cnt_t         cnt_q [WIDTH];
  sync_cnt_t         cnt_d [WIDTH];
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              abort;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_chain #(
      .SYNTHESIS   (SYNTHESIS),
      .STAGES      (STAGES),
      .RESET_VALUE (RESET_VALUE[i]),
      .SEED        (LFSR_W'(32'hA5 + i * 29))
    ) u_chain (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (d_i[i]),
      .sync_o (sync_w[i])
    );
  end

  always_comb begin
    q_d    = q_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    abort  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_w[i] == q_q[i]) begin
        cnt_d[i] = '0;
        if (cnt_q[i] != '0) abort = 1'b1;
      end else if (cnt_q[i] == CNT_LAST) begin
        q_d[i]    = sync_w[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync_w[i];
        fall_d[i] = ~sync_w[i];
      end else begin
        cnt_d[i] = cnt_q[i] + sync_cnt_t'(1);
      end
    end
    // Clear wins over a same-cycle abort; simultaneous aborts count once.
    if (clr_i)                          gcnt_d = '0;
    else if (abort && (gcnt_q != '1))   gcnt_d = gcnt_q + GCNT_W'(1);
    else                                gcnt_d = gcnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q    <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
      gcnt_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      gcnt_q <= gcnt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q_o          = q_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign glitch_cnt_o = gcnt_q;

endmodule
